// File: rtl/riscv_test_pkg.sv
// Shared types and constants for the riscv program-load/run controller.
package riscv_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_FINISH  = 3'd4
    } state_e;

    localparam logic [31:0] MAILBOX_ADDR_DEFAULT = 32'h0000_0FFC;
    localparam logic [31:0] PASS_CODE            = 32'd1;

endpackage

// File: rtl/riscv_cycle_counter.sv
// Saturating, clearable up-counter with enable and equality compare against a threshold.
module riscv_cycle_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] thresh,
    output logic [W-1:0] count,
    output logic         hit
);

    always_ff @(posedge clk) begin
        if (!rst)                       count <= '0;
        else if (clr)                   count <= '0;
        else if (en && (count != '1))   count <= count + 1'b1;
    end

    assign hit = (count == thresh);

endmodule

// File: rtl/riscv_test_ctrl.sv
// Program-load and run controller for the riscv core: load imem, release reset, watch the mailbox.
// Optional store tracing (port + counter + display) under RISCV_TEST_CTRL_TRACE_EN.
module riscv_test_ctrl
    import riscv_test_pkg::*;
#(
    parameter int                PROG_WORDS     = 8,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] MAILBOX_ADDR   = ADDR_W'(MAILBOX_ADDR_DEFAULT),
    parameter int                TIMEOUT_CYCLES = 1000,
    parameter int                CNT_W          = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [31:0]                   ld_data,
    input  logic                          ld_last,
    output logic                          imem_we,
    output logic [$clog2(PROG_WORDS)-1:0] imem_addr,
    output logic [31:0]                   imem_wdata,
    output logic                          core_rst,
    input  logic                          dm_we,
    input  logic [ADDR_W-1:0]             dm_addr,
    input  logic [31:0]                   dm_wdata,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [31:0]                   result,
    output logic                          timeout,
`ifdef RISCV_TEST_CTRL_TRACE_EN
    output logic [CNT_W-1:0]              stores,
`endif
    output logic [CNT_W-1:0]              cycles
);

    localparam int                IDX_W     = $clog2(PROG_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PROG_WORDS - 1);
    localparam logic [CNT_W-1:0]  TO_THRESH = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state;
    logic [IDX_W-1:0] idx;
    logic             launch;
    logic             in_run;
    logic             mbox_hit;
    logic             to_hit;

    assign launch   = start && ((state == ST_IDLE) || (state == ST_FINISH));
    assign in_run   = (state == ST_RUN);
    assign mbox_hit = in_run && dm_we && (dm_addr == MAILBOX_ADDR);

    assign ld_ready = (state == ST_LOAD);
    assign core_rst = !in_run;
    assign busy     = (state == ST_LOAD) || (state == ST_RELEASE) || in_run;

    riscv_cycle_counter #(.W(CNT_W)) u_cycles (
        .clk    (clk),
        .rst    (rst),
        .clr    (launch),
        .en     (in_run),
        .thresh (TO_THRESH),
        .count  (cycles),
        .hit    (to_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            result     <= '0;
            timeout    <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_FINISH: begin
                    if (start) begin
                        state   <= ST_LOAD;
                        idx     <= '0;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        result  <= '0;
                        timeout <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= idx;
                        imem_wdata <= ld_data;
                        // A full memory ends the load; the index never wraps.
                        if (ld_last || (idx == LAST_IDX)) state <= ST_RELEASE;
                        else                              idx   <= idx + 1'b1;
                    end
                end
                ST_RELEASE: state <= ST_RUN;
                ST_RUN: begin
                    // Mailbox takes priority over a coincident timeout.
                    if (mbox_hit) begin
                        done   <= 1'b1;
                        result <= dm_wdata;
                        pass   <= (dm_wdata == PASS_CODE);
                        state  <= ST_FINISH;
                    end else if (to_hit) begin
                        timeout <= 1'b1;
                        state   <= ST_FINISH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RISCV_TEST_CTRL_TRACE_EN
    logic store_hit;

    riscv_cycle_counter #(.W(CNT_W)) u_stores (
        .clk    (clk),
        .rst    (rst),
        .clr    (launch),
        .en     (in_run && dm_we),
        .thresh ('1),
        .count  (stores),
        .hit    (store_hit)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && in_run && dm_we)
            $display("[%0t] riscv store addr=%h data=%h", $time, dm_addr, dm_wdata);
    end
`endif
`endif

endmodule

// File: tb/tb_riscv_test_ctrl.sv
// Self-checking bench for riscv_test_ctrl: imem-write scoreboard plus directed run checks.
module tb_riscv_test_ctrl;

    localparam int          PW   = 8;
    localparam int          TO   = 50;
    localparam logic [31:0] MBOX = 32'h0000_0FFC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        imem_we;
    logic [2:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        busy, done, pass, timeout;
    logic [31:0] result;
    logic [31:0] cycles;

    riscv_test_ctrl #(
        .PROG_WORDS     (PW),
        .ADDR_W         (32),
        .MAILBOX_ADDR   (MBOX),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .result     (result),
        .timeout    (timeout),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t wr_q[$];
    wr_t mon_e;
    int  exp_idx;
    int  acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every imem write must match the oldest accepted word, in order.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("imem_extra_wr", 64'd1, 64'd0);
            end else begin
                mon_e = wr_q.pop_front();
                chk("imem_addr", 64'(imem_addr), 64'(mon_e.addr));
                chk("imem_data", 64'(imem_wdata), 64'(mon_e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start();
        exp_idx = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load(input int n, input bit use_last, output int accepted);
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = $urandom;
            ld_last  = use_last && (i == n - 1);
            if (ld_ready) begin
                wr_t w;
                w.addr = 3'(exp_idx);
                w.data = ld_data;
                wr_q.push_back(w);
                exp_idx++;
                accepted++;
            end
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        dm_we = 1'b1; dm_addr = a; dm_wdata = d;
        tick();
        dm_we = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ld_ready"}, 64'(ld_ready), 64'd0);
        chk({tag, "_imem_we"},  64'(imem_we),  64'd0);
        chk({tag, "_imem_addr"},64'(imem_addr),64'd0);
        chk({tag, "_core_rst"}, 64'(core_rst), 64'd1);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_done"},     64'(done),     64'd0);
        chk({tag, "_pass"},     64'(pass),     64'd0);
        chk({tag, "_result"},   64'(result),   64'd0);
        chk({tag, "_timeout"},  64'(timeout),  64'd0);
        chk({tag, "_cycles"},   64'(cycles),   64'd0);
    endtask

    initial begin
        idle(2);
        chk_reset("por");
        rst = 1'b1;
        tick();

        // Three-word load with ld_last, then a passing mailbox store.
        do_start();
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_ld_ready", 64'(ld_ready), 64'd1);
        load(3, 1'b1, acc);
        chk("t1_accepted", 64'(acc), 64'd3);
        chk("t1_core_rst_release", 64'(core_rst), 64'd1);
        tick();
        chk("t1_core_rst_run", 64'(core_rst), 64'd0);
        chk("t1_wr_q_empty", 64'(wr_q.size()), 64'd0);
        idle(4);
        store(32'h0000_0100, 32'd9);
        chk("t1_non_mbox_done", 64'(done), 64'd0);
        chk("t1_non_mbox_busy", 64'(busy), 64'd1);
        idle(4);
        store(MBOX, 32'd1);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_pass", 64'(pass), 64'd1);
        chk("t1_result", 64'(result), 64'd1);
        chk("t1_timeout", 64'(timeout), 64'd0);
        chk("t1_core_rst", 64'(core_rst), 64'd1);
        chk("t1_busy_fin", 64'(busy), 64'd0);
        chk("t1_cycles", 64'(cycles), 64'd10);
        idle(3);
        chk("t1_cycles_hold", 64'(cycles), 64'd10);
        chk("t1_done_hold", 64'(done), 64'd1);

        // Failing mailbox code.
        do_start();
        chk("t2_done_clr", 64'(done), 64'd0);
        chk("t2_cycles_clr", 64'(cycles), 64'd0);
        load(2, 1'b1, acc);
        tick();
        idle(2);
        store(MBOX, 32'd5);
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_pass", 64'(pass), 64'd0);
        chk("t2_result", 64'(result), 64'd5);
        chk("t2_cycles", 64'(cycles), 64'd3);

        // Timeout with no mailbox store.
        do_start();
        load(1, 1'b1, acc);
        tick();
        idle(TO - 1);
        chk("t3_pre_timeout", 64'(timeout), 64'd0);
        chk("t3_pre_busy", 64'(busy), 64'd1);
        chk("t3_pre_cycles", 64'(cycles), 64'(TO - 1));
        tick();
        chk("t3_timeout", 64'(timeout), 64'd1);
        chk("t3_done", 64'(done), 64'd0);
        chk("t3_cycles", 64'(cycles), 64'(TO));
        chk("t3_core_rst", 64'(core_rst), 64'd1);
        idle(2);
        chk("t3_cycles_hold", 64'(cycles), 64'(TO));

        // Mailbox store coincident with the timeout threshold.
        do_start();
        load(1, 1'b1, acc);
        tick();
        idle(TO - 1);
        store(MBOX, 32'd1);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_timeout", 64'(timeout), 64'd0);
        chk("t4_pass", 64'(pass), 64'd1);
        chk("t4_cycles", 64'(cycles), 64'(TO));

        // Overlong program without ld_last: only PW words land.
        do_start();
        load(PW, 1'b0, acc);
        chk("t5_accepted", 64'(acc), 64'(PW));
        chk("t5_ld_ready_drop", 64'(ld_ready), 64'd0);
        load(2, 1'b0, acc);
        chk("t5_extra_accepted", 64'(acc), 64'd0);
        chk("t5_wr_q_empty", 64'(wr_q.size()), 64'd0);
        store(MBOX, 32'd1);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_cycles", 64'(cycles), 64'd2);

        // Reset mid-LOAD.
        do_start();
        load(2, 1'b0, acc);
        rst = 1'b0;
        tick();
        chk_reset("rst_load");
        chk("rst_load_wr_q", 64'(wr_q.size()), 64'd0);
        rst = 1'b1;
        tick();

        // Reset mid-RUN.
        do_start();
        load(1, 1'b1, acc);
        tick();
        idle(5);
        chk("rst_run_pre_core_rst", 64'(core_rst), 64'd0);
        rst = 1'b0;
        tick();
        chk_reset("rst_run");
        rst = 1'b1;
        tick();

        // Clean run after the aborts.
        do_start();
        load(2, 1'b1, acc);
        chk("t6_core_rst_release", 64'(core_rst), 64'd1);
        tick();
        chk("t6_core_rst_run", 64'(core_rst), 64'd0);
        idle(3);
        store(MBOX, 32'd1);
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_pass", 64'(pass), 64'd1);
        chk("t6_cycles", 64'(cycles), 64'd4);
        chk("t6_wr_q_empty", 64'(wr_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_test_ctrl.md
Name: riscv_test_ctrl

Overview:
- Synthesizable program-load and run controller for the riscv core; generalizes the directed bench flow (file load, reset pulse, free run) into a reusable block.
- Streams a program of PROG_WORDS words into instruction memory and holds the core in reset while loading.
- Releases the core, counts cycles, and detects end-of-test from a store to a mailbox address, with a timeout.
- Sits between the bench or host and the riscv top.

Parameters:
- PROG_WORDS, 8, maximum program length in 32-bit words (instruction memory depth).
- ADDR_W, 32, width of the monitored data-memory address.
- MAILBOX_ADDR, 32'h0000_0FFC, store address that ends the test.
- TIMEOUT_CYCLES, 1000, run cycles before timeout is declared.
- CNT_W, 32, width of the cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load/run sequence.
- ld_valid  in  1  program word valid.
- ld_ready  out  1  controller accepts a word.
- ld_data  in  32  instruction word.
- ld_last  in  1  marks the final word.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  $clog2(PROG_WORDS)  word index.
- imem_wdata  out  32  word to write.
- core_rst  out  1  active-high reset to the riscv core.
- dm_we  in  1  core data-store enable (monitored).
- dm_addr  in  ADDR_W  core store address.
- dm_wdata  in  32  core store data.
- busy  out  1  sequence in progress.
- done  out  1  mailbox store seen (sticky).
- pass  out  1  valid with done; set when the mailbox data equals 1.
- result  out  32  captured mailbox data.
- timeout  out  1  run exceeded TIMEOUT_CYCLES (sticky).
- cycles  out  CNT_W  run cycles counted.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State IDLE.
  - core_rst=1.
  - ld_ready=0, imem_we=0, imem_addr=0, busy=0, done=0, pass=0, result=0, timeout=0, cycles=0.
- States: IDLE, LOAD, RELEASE, RUN, FINISH.
- IDLE:
  - core_rst=1.
  - On start: clear done, pass, result, timeout, cycles and the word index; go to LOAD; set busy=1.
- LOAD:
  - ld_ready=1.
  - On ld_valid and ld_ready in the same cycle, the next cycle has imem_we=1, imem_wdata=ld_data, imem_addr=index; the index then increments.
  - ld_last accepted → RELEASE.
  - Index reaching PROG_WORDS-1 on an accept forces RELEASE, even without ld_last. Extra words are never written and there is no wrap.
  - start is ignored while busy.
- RELEASE:
  - Exactly one cycle; core_rst held 1 while the last write completes.
  - Go to RUN.
- RUN:
  - core_rst=0.
  - cycles increments every cycle, saturating at all ones.
  - dm_we=1 with dm_addr==MAILBOX_ADDR → next cycle done=1, result=dm_wdata, pass=(dm_wdata==1); go to FINISH.
  - cycles==TIMEOUT_CYCLES-1 with no mailbox store → timeout=1; go to FINISH.
  - A mailbox store in the same cycle as the timeout threshold: the mailbox wins, so done=1 and timeout=0.
- FINISH:
  - core_rst=1, busy=0.
  - Flags and cycles hold until the next start; then go to LOAD.
- A reset in any state aborts immediately to reset values; partial loads are discarded and core_rst is reasserted.
- Latency: the first core fetch occurs 2 cycles after the ld_last handshake.

Optional Feature:
- Macro RISCV_TEST_CTRL_TRACE_EN.
- When defined:
  - Adds output port stores (CNT_W): count of dm_we cycles during RUN.
  - Adds a simulation-only $display per store: time, address, data.
- When undefined: no port, no counter, no display.

Decomposition:
- Package riscv_test_pkg holds:
  - the typedef enum for the state;
  - MAILBOX_ADDR_DEFAULT;
  - the PASS_CODE constant (32'd1).
- One sub-module, riscv_cycle_counter: a saturating, clearable counter with enable and threshold compare (used for cycles and, under the macro, stores).

Test Plan:
- Load 3 words via ld_valid with ld_last on the third → imem_we pulses at addr 0,1,2 with matching data; core_rst falls 2 cycles after the last handshake.
- Program stores 32'd1 to 0xFFC → done=1, pass=1, result=1; core_rst=1; cycles equals the run length.
- Program stores 32'd5 to 0xFFC → done=1, pass=0, result=5.
- Program loops forever with TIMEOUT_CYCLES=50 → timeout=1 with cycles=50 and done=0; a simultaneous mailbox store at cycle 49 gives done=1 and timeout=0.
- Stream 10 words into PROG_WORDS=8 without ld_last → only addresses 0..7 are written; ld_ready drops after the eighth word.
- Assert rst=0 mid-LOAD and again mid-RUN → all outputs return to reset values on the next edge; start then runs cleanly.
